// File: rtl/nbit_universal_shift_register.sv
// WIDTH-bit universal shift register with STEP-bit moves, eight modes and a counted burst engine.
// Optional even-parity output register: define NBIT_USR_PARITY_EN.
module nbit_universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  sin_lsb,
    input  logic [STEP-1:0]  sin_msb,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [WIDTH-1:0] outdata,
    output logic [STEP-1:0]  sout_msb,
    output logic [STEP-1:0]  sout_lsb,
    output logic             busy,
`ifdef NBIT_USR_PARITY_EN
    output logic             parity,
`endif
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_SHL   = 3'd1,
        OP_SHR   = 3'd2,
        OP_ROL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ASR   = 3'd5,
        OP_LOAD  = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem;
    logic [2:0]       op_sel;
    logic             do_op;
    logic [WIDTH-1:0] next_data;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [STEP-1:0]  sl,
        input logic [STEP-1:0]  sm,
        input logic [WIDTH-1:0] pd
    );
        case (op)
            OP_SHL:   return {cur[WIDTH-STEP-1:0], sl};
            OP_SHR:   return {sm, cur[WIDTH-1:STEP]};
            OP_ROL:   return {cur[WIDTH-STEP-1:0], cur[WIDTH-1 -: STEP]};
            OP_ROR:   return {cur[STEP-1:0], cur[WIDTH-1:STEP]};
            OP_ASR:   return $unsigned($signed(cur) >>> STEP);
            OP_LOAD:  return pd;
            OP_CLEAR: return '0;
            default:  return cur;
        endcase
    endfunction

    // A burst replays the latched mode; a single idle-cycle op uses the live mode.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        op_sel    = mode;
        do_op     = 1'b0;
        next_data = outdata;
        if (state == RUN) begin
            op_sel = mode_q;
            do_op  = 1'b1;
        end else if (state == IDLE && !start && enable) begin
            do_op  = 1'b1;
        end
        if (do_op)
            next_data = apply_op(op_sel, outdata, sin_lsb, sin_msb, pdata);
    end

    // NOTE: resetn is synchronous, so it appears only inside the clocked branch, never in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            mode_q  <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            outdata <= '0;
        end else begin
            outdata <= next_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        rem    <= burst_cnt;
                        busy   <= 1'b1;
                        if (burst_cnt != '0) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rem != '0)
                        rem <= rem - CNT_W'(1);
                    if (rem <= CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NBIT_USR_PARITY_EN
    // Parity tracks the value written on the same edge, so it never lags outdata.
    always_ff @(posedge clk) begin
        if (!resetn)
            parity <= 1'b0;
        else
            parity <= ^next_data;
    end
`endif

    assign sout_msb = outdata[WIDTH-1 -: STEP];
    assign sout_lsb = outdata[STEP-1:0];

endmodule
